// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: ID-side request and EX/MEM/WB control bundle between front end and control unit
// master = front end / datapath (drives ID fields, flush, stall); slave = control unit (drives stall/illegal and stage controls)
interface pipelined_control_unit_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             ex_flush;
  logic             mem_stall;
  logic             id_stall;
  logic             id_illegal;
  logic             ex_valid;
  logic             ex_alusrc;
  logic             ex_branch;
  logic [1:0]       ex_aluop;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid;
  logic             mem_memread;
  logic             mem_memwrite;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid;
  logic             wb_regwrite;
  logic             wb_memtoreg;
  logic [REG_W-1:0] wb_rd;
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_flush, mem_stall,
    input  id_stall, id_illegal,
    input  ex_valid, ex_alusrc, ex_branch, ex_aluop, ex_rd,
    input  mem_valid, mem_memread, mem_memwrite, mem_rd,
    input  wb_valid, wb_regwrite, wb_memtoreg, wb_rd
  );
  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_flush, mem_stall,
    output id_stall, id_illegal,
    output ex_valid, ex_alusrc, ex_branch, ex_aluop, ex_rd,
    output mem_valid, mem_memread, mem_memwrite, mem_rd,
    output wb_valid, wb_regwrite, wb_memtoreg, wb_rd
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32 subset main decoder with EX/MEM/WB control pipeline, load-use stall, flush and memory stall
// ports: clk, rst_n (async active-low), bus (slave modport: ID request in, id_stall/id_illegal and stage controls out)
module pipelined_control_unit #(
  parameter bit EN_ITYPE  = 1'b1,
  parameter bit EN_HAZARD = 1'b1,
  parameter int REG_W     = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_control_unit_if.slave bus
);
  typedef struct packed {
    logic             valid;
    logic             alusrc;
    logic             memtoreg;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic [1:0]       aluop;
    logic [REG_W-1:0] rd;
  } ctl_t;
  ctl_t dec, id_d, ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
  logic legal, uses_rs1, uses_rs2, hazard;
  always_comb begin
    dec      = '0;
    legal    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (bus.id_opcode)
      7'b0110011: begin
        legal        = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      7'b0000011: begin
        legal        = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        uses_rs1     = 1'b1;
      end
      7'b0100011: begin
        legal        = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      7'b1100011: begin
        legal      = 1'b1;
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      7'b0010011: begin
        legal        = EN_ITYPE;
        dec.alusrc   = EN_ITYPE;
        dec.regwrite = EN_ITYPE;
        dec.aluop    = EN_ITYPE ? 2'b11 : 2'b00;
        uses_rs1     = EN_ITYPE;
      end
      default: ;
    endcase
    dec.valid = 1'b1;
    dec.rd    = bus.id_rd;
    // anything not a real, legal instruction becomes an all-zero bubble
    id_d = (bus.id_valid && legal) ? dec : '0;
  end
  assign hazard = EN_HAZARD && ex_q.valid && ex_q.memread && (ex_q.rd != '0) && bus.id_valid &&
                  ((uses_rs1 && bus.id_rs1 == ex_q.rd) || (uses_rs2 && bus.id_rs2 == ex_q.rd));
  // a memory stall freezes everything; a flush already discards ID, so no stall is needed
  assign bus.id_stall   = hazard && !bus.ex_flush && !bus.mem_stall;
  assign bus.id_illegal = bus.id_valid && !legal;
  assign ex_d  = bus.mem_stall ? ex_q : (bus.ex_flush || hazard) ? '0 : id_d;
  assign mem_d = bus.mem_stall ? mem_q : ex_q;
  assign wb_d  = bus.mem_stall ? wb_q : mem_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_alusrc    = ex_q.valid & ex_q.alusrc;
  assign bus.ex_branch    = ex_q.valid & ex_q.branch;
  assign bus.ex_aluop     = ex_q.valid ? ex_q.aluop : 2'b00;
  assign bus.ex_rd        = ex_q.valid ? ex_q.rd : '0;
  assign bus.mem_valid    = mem_q.valid;
  assign bus.mem_memread  = mem_q.valid & mem_q.memread;
  assign bus.mem_memwrite = mem_q.valid & mem_q.memwrite;
  assign bus.mem_rd       = mem_q.valid ? mem_q.rd : '0;
  assign bus.wb_valid     = wb_q.valid;
  assign bus.wb_regwrite  = wb_q.valid & wb_q.regwrite;
  assign bus.wb_memtoreg  = wb_q.valid & wb_q.memtoreg;
  assign bus.wb_rd        = wb_q.valid ? wb_q.rd : '0;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: decode table, WB scoreboard and hand sequences for hazard, flush, stall and reset
module tb_pipelined_control_unit;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_X  = 7'b1111111;
  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
    logic       ill;
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st_q = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  vec_t v [7];
  vec_t sbq [$];
  vec_t e;
  always #5 clk = ~clk;
  pipelined_control_unit_if #(.REG_W(5)) bus ();
  pipelined_control_unit_if #(.REG_W(5)) bus1 ();
  pipelined_control_unit #(.EN_ITYPE(1'b1), .EN_HAZARD(1'b1), .REG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_control_unit #(.EN_ITYPE(1'b0), .EN_HAZARD(1'b0), .REG_W(5)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  assign bus1.id_valid  = bus.id_valid;
  assign bus1.id_opcode = bus.id_opcode;
  assign bus1.id_rs1    = bus.id_rs1;
  assign bus1.id_rs2    = bus.id_rs2;
  assign bus1.id_rd     = bus.id_rd;
  assign bus1.ex_flush  = bus.ex_flush;
  assign bus1.mem_stall = bus.mem_stall;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(logic vld, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    bus.id_valid  = vld;
    bus.id_opcode = op;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
    bus.id_rd     = rd;
  endtask
  task automatic chk_all_zero(string nm);
    chk({nm, "_ex"}, {bus.ex_valid, bus.ex_alusrc, bus.ex_branch, bus.ex_aluop, bus.ex_rd}, 0);
    chk({nm, "_mem"}, {bus.mem_valid, bus.mem_memread, bus.mem_memwrite, bus.mem_rd}, 0);
    chk({nm, "_wb"}, {bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd}, 0);
  endtask
  always @(posedge clk) st_q <= bus.mem_stall;
  // each instruction shows up in WB once; a stalled edge repeats the previous view and is skipped
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && !st_q) begin
      if (sbq.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("wb_rd", bus.wb_rd, e.rd);
        chk("wb_regwrite", bus.wb_regwrite, e.regwrite);
        chk("wb_memtoreg", bus.wb_memtoreg, e.memtoreg);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t t;
    v[0] = '{op: OP_R,  rd: 5'd5,  ill: 1'b0, aluop: 2'b10, alusrc: 1'b0, branch: 1'b0, memread: 1'b0, memwrite: 1'b0, regwrite: 1'b1, memtoreg: 1'b0};
    v[1] = '{op: OP_LD, rd: 5'd7,  ill: 1'b0, aluop: 2'b00, alusrc: 1'b1, branch: 1'b0, memread: 1'b1, memwrite: 1'b0, regwrite: 1'b1, memtoreg: 1'b1};
    v[2] = '{op: OP_ST, rd: 5'd3,  ill: 1'b0, aluop: 2'b00, alusrc: 1'b1, branch: 1'b0, memread: 1'b0, memwrite: 1'b1, regwrite: 1'b0, memtoreg: 1'b0};
    v[3] = '{op: OP_BR, rd: 5'd9,  ill: 1'b0, aluop: 2'b01, alusrc: 1'b0, branch: 1'b1, memread: 1'b0, memwrite: 1'b0, regwrite: 1'b0, memtoreg: 1'b0};
    v[4] = '{op: OP_I,  rd: 5'd11, ill: 1'b0, aluop: 2'b11, alusrc: 1'b1, branch: 1'b0, memread: 1'b0, memwrite: 1'b0, regwrite: 1'b1, memtoreg: 1'b0};
    v[5] = '{op: OP_X,  rd: 5'd4,  ill: 1'b1, aluop: 2'b00, alusrc: 1'b0, branch: 1'b0, memread: 1'b0, memwrite: 1'b0, regwrite: 1'b0, memtoreg: 1'b0};
    v[6] = '{op: OP_R,  rd: 5'd0,  ill: 1'b0, aluop: 2'b10, alusrc: 1'b0, branch: 1'b0, memread: 1'b0, memwrite: 1'b0, regwrite: 1'b1, memtoreg: 1'b0};
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    bus.ex_flush  = 1'b0;
    bus.mem_stall = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // decode table, one instruction per cycle
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, v[i].op, 5'd1, 5'd2, v[i].rd);
      if (!v[i].ill) sbq.push_back(v[i]);
      #1;
      chk("id_illegal", bus.id_illegal, v[i].ill);
      chk("id_illegal_noitype", bus1.id_illegal, v[i].ill || v[i].op == OP_I);
      chk("id_stall_table", bus.id_stall, 0);
      step();
      chk("ex_valid", bus.ex_valid, !v[i].ill);
      chk("ex_alusrc", bus.ex_alusrc, v[i].alusrc);
      chk("ex_branch", bus.ex_branch, v[i].branch);
      chk("ex_aluop", bus.ex_aluop, v[i].aluop);
      chk("ex_rd", bus.ex_rd, v[i].ill ? 5'd0 : v[i].rd);
      chk("ex_valid_noitype", bus1.ex_valid, !(v[i].ill || v[i].op == OP_I));
      if (i > 0) begin
        chk("mem_valid", bus.mem_valid, !v[i-1].ill);
        chk("mem_memread", bus.mem_memread, v[i-1].memread);
        chk("mem_memwrite", bus.mem_memwrite, v[i-1].memwrite);
        chk("mem_rd", bus.mem_rd, v[i-1].ill ? 5'd0 : v[i-1].rd);
      end
    end
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (4) step();
    // load-use: LD x7 then R reading x7 stalls exactly one cycle
    drv(1'b1, OP_LD, 5'd1, 5'd2, 5'd7);
    sbq.push_back(v[1]);
    step();
    drv(1'b1, OP_R, 5'd7, 5'd3, 5'd8);
    #1;
    chk("lu_id_stall", bus.id_stall, 1);
    chk("lu_id_stall_nohaz", bus1.id_stall, 0);
    step();
    chk("lu_ex_bubble", bus.ex_valid, 0);
    chk("lu_mem_memread", bus.mem_memread, 1);
    chk("lu_mem_rd", bus.mem_rd, 7);
    chk("lu_stall_released", bus.id_stall, 0);
    t = v[0];
    t.rd = 5'd8;
    sbq.push_back(t);
    step();
    chk("lu_r_ex_valid", bus.ex_valid, 1);
    chk("lu_r_ex_rd", bus.ex_rd, 8);
    chk("lu_r_ex_aluop", bus.ex_aluop, 2'b10);
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (4) step();
    // load to x0 never stalls
    t = v[1];
    t.rd = 5'd0;
    drv(1'b1, OP_LD, 5'd1, 5'd2, 5'd0);
    sbq.push_back(t);
    step();
    drv(1'b1, OP_R, 5'd0, 5'd3, 5'd8);
    t = v[0];
    t.rd = 5'd8;
    sbq.push_back(t);
    #1;
    chk("x0_id_stall", bus.id_stall, 0);
    step();
    chk("x0_ex_valid", bus.ex_valid, 1);
    chk("x0_ex_rd", bus.ex_rd, 8);
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (4) step();
    // branch flush squashes the ADD in ID, branch proceeds to MEM
    drv(1'b1, OP_BR, 5'd1, 5'd2, 5'd9);
    sbq.push_back(v[3]);
    step();
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd10);
    bus.ex_flush = 1'b1;
    #1;
    chk("fl_id_stall", bus.id_stall, 0);
    step();
    bus.ex_flush = 1'b0;
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    chk("fl_ex_valid", bus.ex_valid, 0);
    chk("fl_mem_valid", bus.mem_valid, 1);
    chk("fl_mem_rd", bus.mem_rd, 9);
    repeat (4) step();
    // flush wins over a pending load-use hazard
    drv(1'b1, OP_LD, 5'd1, 5'd2, 5'd7);
    sbq.push_back(v[1]);
    step();
    drv(1'b1, OP_R, 5'd7, 5'd2, 5'd10);
    bus.ex_flush = 1'b1;
    #1;
    chk("flhz_id_stall", bus.id_stall, 0);
    step();
    bus.ex_flush = 1'b0;
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    chk("flhz_ex_valid", bus.ex_valid, 0);
    repeat (4) step();
    // memory stall for 3 cycles holds every stage
    drv(1'b1, v[0].op, 5'd1, 5'd2, v[0].rd);
    sbq.push_back(v[0]);
    step();
    drv(1'b1, v[2].op, 5'd1, 5'd2, v[2].rd);
    sbq.push_back(v[2]);
    step();
    drv(1'b1, v[3].op, 5'd1, 5'd2, v[3].rd);
    sbq.push_back(v[3]);
    step();
    drv(1'b1, v[4].op, 5'd1, 5'd2, v[4].rd);
    bus.mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ms_ex_rd", bus.ex_rd, 9);
      chk("ms_ex_branch", bus.ex_branch, 1);
      chk("ms_mem_rd", bus.mem_rd, 3);
      chk("ms_mem_memwrite", bus.mem_memwrite, 1);
      chk("ms_wb_rd", bus.wb_rd, 5);
      chk("ms_wb_regwrite", bus.wb_regwrite, 1);
      chk("ms_id_stall", bus.id_stall, 0);
    end
    bus.mem_stall = 1'b0;
    sbq.push_back(v[4]);
    step();
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    chk("ms_resume_ex_rd", bus.ex_rd, 11);
    chk("ms_resume_mem_rd", bus.mem_rd, 9);
    chk("ms_resume_wb_rd", bus.wb_rd, 3);
    repeat (4) step();
    // reset mid-stream drops everything at once
    drv(1'b1, v[0].op, 5'd1, 5'd2, v[0].rd);
    sbq.push_back(v[0]);
    step();
    drv(1'b1, v[1].op, 5'd1, 5'd2, v[1].rd);
    sbq.push_back(v[1]);
    step();
    chk("rst_pre_ex_valid", bus.ex_valid, 1);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk_all_zero("rst_mid");
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_post_ex_valid", bus.ex_valid, 0);
    chk("rst_post_wb_valid", bus.wb_valid, 0);
    repeat (3) step();
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
